ysyx_23060203_idu: RTL and testbench
====================================

# ysyx_23060203_idu

Instruction decode stage directly downstream of the instruction-fetch stage. Accepts one `{pc, inst}` per valid/ready handshake and decodes it into register indices, a sign-extended immediate, an operation class and control flags. The decoded bundle is held in a single output pipeline register. The block honours the same redirect `flush` that the fetch stage receives and presents the register to the execute stage with valid/ready backpressure.

## Interface
Parameters:
- None. Widths are fixed: XLEN 32, register index 5 bits.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `flush` in 1: redirect from execute; kills the held entry and any same-cycle input.
- `in_valid` in 1: fetch output valid.
- `in_ready` out 1: decode can accept.
- `in_pc` in 32: PC of the incoming instruction.
- `in_inst` in 32: raw instruction.
- `out_valid` out 1: decoded bundle valid (`out_valid_r & ~flush`).
- `out_ready` in 1: execute accepts.
- `out_pc`, `out_inst` out 32: registered copies of the input.
- `out_rs1`, `out_rs2`, `out_rd` out 5: register indices, forced to 0 when unused by the format.
- `out_imm` out 32: sign-extended immediate.
- `out_op` out 4: `op_t` class.
- `out_funct3` out 3; `out_alt` out 1: `inst[30]`, meaningful only for OP and shift OPIMM.
- `out_rf_wen` out 1: rd written, forced 0 when rd == 0.
- `out_illegal`, `out_fencei`, `out_ecall`, `out_ebreak`, `out_mret` out 1.

## Operation
- `in_ready = ~out_valid_r | out_ready`, independent of `flush`.
- Load occurs when `in_valid & in_ready & ~flush`: `out_valid_r <= 1` and all decoded fields are registered.
- `flush` clears `out_valid_r` on the next edge and discards any same-cycle input. `out_valid` is already 0 in the flush cycle.
- Drain without refill (`out_ready & ~load`): `out_valid_r <= 0`. Field registers hold their values.
- Op classes (`op_t`): LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, FENCE, SYSTEM, ILLEGAL.
- Immediate formats:
  - I: `{{20{i[31]}}, i[31:20]}`.
  - S: `i[31:25]`, `i[11:7]`.
  - B: `i[31]`, `i[7]`, `i[30:25]`, `i[11:8]`, `0`.
  - U: `{i[31:12], 12'b0}`.
  - J: `i[31]`, `i[19:12]`, `i[20]`, `i[30:21]`, `0`.
  - R-type: 0.
- Illegal is flagged for:
  - `inst[1:0] != 2'b11`;
  - an unknown opcode;
  - an undefined funct3 in BRANCH (010, 011), LOAD (011, 110, 111) or STORE (>= 011);
  - OP with funct7 other than 0x00, or 0x20 combined with funct3 000/101;
  - SYSTEM with funct3 100.
- When illegal: `out_op = ILLEGAL` and `out_rf_wen = 0`.
- FENCE with funct3 001 sets `out_fencei`.
- SYSTEM flag decode (exact encodings):
  - `0x00000073` → `ecall`;
  - `0x00100073` → `ebreak`;
  - `0x30200073` → `mret`;
  - any other funct3 000 → illegal;
  - CSR funct3 values → SYSTEM with `rf_wen`.

## Timing
- Latency is 1 cycle: a handshake at edge N gives `out_valid` after edge N.
- Full throughput, 1 instruction per cycle, while `out_ready` is held high.
- Reset values: `out_valid_r = 0` (so `out_valid = 0`), all field outputs 0, `out_op = ILLEGAL`.
- Reset is applied asynchronously. Reset mid-transfer drops the held entry with no partial output.
- Flush together with `out_ready`: the entry is dropped and nothing is accepted.
- Flush with no held entry: no effect beyond blocking the load.

## Configuration
- `YSYX_23060203_RVE_EN`:
  - Defined: RV32E. Any used rs1/rs2/rd index >= 16 sets `out_illegal`, `out_op = ILLEGAL`, `out_rf_wen = 0`.
  - Undefined: RV32I, all 32 indices legal.

## Structure
- `op_t` and the opcode constants (`OPC_LUI` = 5'b01101, …) live in the shared package `ysyx_23060203_pkg` so that execute can use them.
- Combinational decoder sub-module: `ysyx_23060203_idu_dec`, mapping inst to a fields struct (`dec_t`, also in the package).
- The top level holds only the handshake and the pipeline register.

## Test plan
- `0x00500093` (addi x1,x0,5) → OPIMM, rd=1, rs1=0, imm=5, `rf_wen=1`, `out_valid` one cycle after acceptance.
- `0x12345137` (lui x2) → LUI, imm=0x12345000, rs1=rs2=0.
- `0xfe000ee3` (beq x0,x0,-4) → BRANCH, imm=0xFFFFFFFC, `rf_wen=0`.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, `out_*` stable; release → back-to-back transfers with no loss or duplication.
- `flush=1` in the same cycle as an input handshake while an entry is held → `out_valid=0` in that cycle and the next; no instruction is emitted.
- `0x00100813` (addi x16,x0,1): with RVE → illegal, `rf_wen=0`; without RVE → OPIMM, rd=16.

Source files
------------

// File: rtl/ysyx_23060203_pkg.sv
// Shared decode definitions: op classes, opcode constants and the decoded-fields bundle.
// Used by the decode stage and the execute stage.
package ysyx_23060203_pkg;

   typedef enum logic [3:0] {
      OP_LUI     = 4'd0,
      OP_AUIPC   = 4'd1,
      OP_JAL     = 4'd2,
      OP_JALR    = 4'd3,
      OP_BRANCH  = 4'd4,
      OP_LOAD    = 4'd5,
      OP_STORE   = 4'd6,
      OP_OPIMM   = 4'd7,
      OP_OP      = 4'd8,
      OP_FENCE   = 4'd9,
      OP_SYSTEM  = 4'd10,
      OP_ILLEGAL = 4'd11
   } op_t;

   // Opcode constants are inst[6:2]; inst[1:0] must be 2'b11.
   localparam logic [4:0] OPC_LOAD     = 5'b00000;
   localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPC_OPIMM    = 5'b00100;
   localparam logic [4:0] OPC_AUIPC    = 5'b00101;
   localparam logic [4:0] OPC_STORE    = 5'b01000;
   localparam logic [4:0] OPC_OP       = 5'b01100;
   localparam logic [4:0] OPC_LUI      = 5'b01101;
   localparam logic [4:0] OPC_BRANCH   = 5'b11000;
   localparam logic [4:0] OPC_JALR     = 5'b11001;
   localparam logic [4:0] OPC_JAL      = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      op_t         op;
      logic [2:0]  funct3;
      logic        alt;
      logic        rf_wen;
      logic        illegal;
      logic        fencei;
      logic        ecall;
      logic        ebreak;
      logic        mret;
   } dec_t;

   localparam dec_t DEC_RESET = '{
      rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, op: OP_ILLEGAL,
      funct3: 3'd0, alt: 1'b0, rf_wen: 1'b0, illegal: 1'b0,
      fencei: 1'b0, ecall: 1'b0, ebreak: 1'b0, mret: 1'b0
   };

endpackage

// File: rtl/ysyx_23060203_idu_dec.sv
// Combinational RV32I/RV32E instruction decoder: raw instruction -> dec_t.
// Define YSYX_23060203_RVE_EN to reject register indices >= 16 (RV32E).
module ysyx_23060203_idu_dec
   import ysyx_23060203_pkg::*;
(
   input  logic [31:0] inst,
   output dec_t        dec
);

   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   op_t         op;
   logic        ill, wr, use_rs1, use_rs2, use_rd;
   logic        fencei, ecall, ebreak, mret;

   assign opc   = inst[6:2];
   assign f3    = inst[14:12];
   assign f7    = inst[31:25];
   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      op      = OP_ILLEGAL;
      ill     = 1'b1;
      imm     = 32'd0;
      wr      = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      use_rd  = 1'b0;
      fencei  = 1'b0;
      ecall   = 1'b0;
      ebreak  = 1'b0;
      mret    = 1'b0;
      if (inst[1:0] == 2'b11) begin
         case (opc)
            OPC_LUI:   begin op = OP_LUI;   ill = 1'b0; imm = imm_u; use_rd = 1'b1; wr = 1'b1; end
            OPC_AUIPC: begin op = OP_AUIPC; ill = 1'b0; imm = imm_u; use_rd = 1'b1; wr = 1'b1; end
            OPC_JAL:   begin op = OP_JAL;   ill = 1'b0; imm = imm_j; use_rd = 1'b1; wr = 1'b1; end
            OPC_JALR: begin
               op = OP_JALR; ill = 1'b0; imm = imm_i;
               use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
            end
            OPC_BRANCH: begin
               op = OP_BRANCH; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
               ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
               op = OP_LOAD; imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
               ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
               op = OP_STORE; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
               ill = (f3 >= 3'b011);
            end
            OPC_OPIMM: begin
               op = OP_OPIMM; ill = 1'b0; imm = imm_i;
               use_rd = 1'b1; use_rs1 = 1'b1; wr = 1'b1;
            end
            OPC_OP: begin
               op = OP_OP; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; wr = 1'b1;
               // funct7 0x20 is only defined for SUB and SRA.
               ill = !((f7 == 7'h00) ||
                       ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_MISC_MEM: begin
               op = OP_FENCE; ill = 1'b0; imm = imm_i;
               use_rd = 1'b1; use_rs1 = 1'b1;
               fencei = (f3 == 3'b001);
            end
            OPC_SYSTEM: begin
               op = OP_SYSTEM; imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
               if (f3 == 3'b000) begin
                  ecall  = (inst == 32'h0000_0073);
                  ebreak = (inst == 32'h0010_0073);
                  mret   = (inst == 32'h3020_0073);
                  ill    = !(ecall || ebreak || mret);
               end else begin
                  ill = (f3 == 3'b100);
                  wr  = 1'b1;
               end
            end
            default: ill = 1'b1;
         endcase
      end
`ifdef YSYX_23060203_RVE_EN
      if ((use_rs1 && inst[19]) || (use_rs2 && inst[24]) || (use_rd && inst[11]))
         ill = 1'b1;
`endif
   end

   assign rs1 = use_rs1 ? inst[19:15] : 5'd0;
   assign rs2 = use_rs2 ? inst[24:20] : 5'd0;
   assign rd  = use_rd  ? inst[11:7]  : 5'd0;

   always_comb begin
      dec         = DEC_RESET;
      dec.rs1     = rs1;
      dec.rs2     = rs2;
      dec.rd      = rd;
      dec.imm     = imm;
      dec.op      = ill ? OP_ILLEGAL : op;
      dec.funct3  = f3;
      dec.alt     = inst[30];
      dec.rf_wen  = wr && !ill && (rd != 5'd0);
      dec.illegal = ill;
      dec.fencei  = fencei && !ill;
      dec.ecall   = ecall  && !ill;
      dec.ebreak  = ebreak && !ill;
      dec.mret    = mret   && !ill;
   end

endmodule

// File: rtl/ysyx_23060203_idu.sv
// Decode stage: valid/ready handshake plus one output pipeline register of decoded fields.
// Build option YSYX_23060203_RVE_EN selects RV32E register checking in the decoder.
module ysyx_23060203_idu
   import ysyx_23060203_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic [31:0] out_imm,
   output logic [3:0]  out_op,
   output logic [2:0]  out_funct3,
   output logic        out_alt,
   output logic        out_rf_wen,
   output logic        out_illegal,
   output logic        out_fencei,
   output logic        out_ecall,
   output logic        out_ebreak,
   output logic        out_mret
);

   dec_t        dec_d, dec_q;
   logic        valid_q;
   logic [31:0] pc_q, inst_q;
   logic        load;

   ysyx_23060203_idu_dec u_dec (
      .inst (in_inst),
      .dec  (dec_d)
   );

   assign in_ready = ~valid_q | out_ready;
   assign load     = in_valid & in_ready & ~flush;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         pc_q    <= 32'd0;
         inst_q  <= 32'd0;
         dec_q   <= DEC_RESET;
      end else begin
         if (flush)          valid_q <= 1'b0;
         else if (load)      valid_q <= 1'b1;
         else if (out_ready) valid_q <= 1'b0;
         if (load) begin
            pc_q   <= in_pc;
            inst_q <= in_inst;
            dec_q  <= dec_d;
         end
      end
   end

   // The flush cycle already hides the held entry from execute.
   assign out_valid   = valid_q & ~flush;
   assign out_pc      = pc_q;
   assign out_inst    = inst_q;
   assign out_rs1     = dec_q.rs1;
   assign out_rs2     = dec_q.rs2;
   assign out_rd      = dec_q.rd;
   assign out_imm     = dec_q.imm;
   assign out_op      = dec_q.op;
   assign out_funct3  = dec_q.funct3;
   assign out_alt     = dec_q.alt;
   assign out_rf_wen  = dec_q.rf_wen;
   assign out_illegal = dec_q.illegal;
   assign out_fencei  = dec_q.fencei;
   assign out_ecall   = dec_q.ecall;
   assign out_ebreak  = dec_q.ebreak;
   assign out_mret    = dec_q.mret;

endmodule

// File: tb/tb_ysyx_23060203_idu.sv
// Directed self-checking bench for the decode stage: decode vectors, backpressure, flush, reset.
module tb_ysyx_23060203_idu;
   import ysyx_23060203_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc, out_inst, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_op;
   logic [2:0]  out_funct3;
   logic        out_alt, out_rf_wen, out_illegal, out_fencei, out_ecall, out_ebreak, out_mret;

   int total = 0;
   int bad   = 0;

   ysyx_23060203_idu dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_inst     (in_inst),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_inst    (out_inst),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_rd      (out_rd),
      .out_imm     (out_imm),
      .out_op      (out_op),
      .out_funct3  (out_funct3),
      .out_alt     (out_alt),
      .out_rf_wen  (out_rf_wen),
      .out_illegal (out_illegal),
      .out_fencei  (out_fencei),
      .out_ecall   (out_ecall),
      .out_ebreak  (out_ebreak),
      .out_mret    (out_mret)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // flg = {illegal, fencei, ecall, ebreak, mret}
   task automatic decode_case(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                              input op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic wen,
                              input logic [4:0] flg);
      in_valid  = 1'b1;
      in_pc     = pc;
      in_inst   = inst;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_pc"}, out_pc, pc);
      check({tag, "_op"}, out_op, op);
      check({tag, "_rd"}, out_rd, rd);
      check({tag, "_rs1"}, out_rs1, rs1);
      check({tag, "_rs2"}, out_rs2, rs2);
      check({tag, "_imm"}, out_imm, imm);
      check({tag, "_wen"}, out_rf_wen, wen);
      check({tag, "_flags"}, {out_illegal, out_fencei, out_ecall, out_ebreak, out_mret}, flg);
   endtask

   initial begin
      #12;
      check("rst_valid", out_valid, 1'b0);
      check("rst_op", out_op, OP_ILLEGAL);
      check("rst_imm", out_imm, 32'd0);
      check("rst_rd", out_rd, 5'd0);
      check("rst_in_ready", in_ready, 1'b1);
      tick();
      reset = 1'b1;
      tick();

      decode_case("addi",   32'h8000_0000, 32'h0050_0093, OP_OPIMM,   5'd1, 5'd0, 5'd0, 32'd5,         1'b1, 5'b00000);
      decode_case("lui",    32'h8000_0004, 32'h1234_5137, OP_LUI,     5'd2, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 5'b00000);
      decode_case("beq",    32'h8000_0008, 32'hfe00_0ee3, OP_BRANCH,  5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0, 5'b00000);
      decode_case("sub",    32'h8000_000c, 32'h4020_81B3, OP_OP,      5'd3, 5'd1, 5'd2, 32'd0,         1'b1, 5'b00000);
      check("sub_alt", out_alt, 1'b1);
      decode_case("badop",  32'h8000_0010, 32'h4020_91B3, OP_ILLEGAL, 5'd3, 5'd1, 5'd2, 32'd0,         1'b0, 5'b10000);
      decode_case("c16",    32'h8000_0014, 32'h0000_0000, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'd0,         1'b0, 5'b10000);
      decode_case("jal",    32'h8000_0018, 32'h0080_00EF, OP_JAL,     5'd1, 5'd0, 5'd0, 32'd8,         1'b1, 5'b00000);
      decode_case("sw",     32'h8000_001c, 32'h0020_A423, OP_STORE,   5'd0, 5'd1, 5'd2, 32'd8,         1'b0, 5'b00000);
      decode_case("ld",     32'h8000_0020, 32'h0001_3083, OP_ILLEGAL, 5'd1, 5'd2, 5'd0, 32'd0,         1'b0, 5'b10000);
      decode_case("ecall",  32'h8000_0024, 32'h0000_0073, OP_SYSTEM,  5'd0, 5'd0, 5'd0, 32'd0,         1'b0, 5'b00100);
      decode_case("ebreak", 32'h8000_0028, 32'h0010_0073, OP_SYSTEM,  5'd0, 5'd0, 5'd0, 32'd1,         1'b0, 5'b00010);
      decode_case("mret",   32'h8000_002c, 32'h3020_0073, OP_SYSTEM,  5'd0, 5'd0, 5'd0, 32'h302,       1'b0, 5'b00001);
      decode_case("wfi",    32'h8000_0030, 32'h1050_0073, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h105,       1'b0, 5'b10000);
      decode_case("csrrw",  32'h8000_0034, 32'h3000_92F3, OP_SYSTEM,  5'd5, 5'd1, 5'd0, 32'h300,       1'b1, 5'b00000);
      decode_case("fencei", 32'h8000_0038, 32'h0000_100F, OP_FENCE,   5'd0, 5'd0, 5'd0, 32'd0,         1'b0, 5'b01000);
`ifdef YSYX_23060203_RVE_EN
      decode_case("rve16",  32'h8000_003c, 32'h0010_0813, OP_ILLEGAL, 5'd16, 5'd0, 5'd0, 32'd1,        1'b0, 5'b10000);
`else
      decode_case("rvi16",  32'h8000_003c, 32'h0010_0813, OP_OPIMM,   5'd16, 5'd0, 5'd0, 32'd1,        1'b1, 5'b00000);
`endif
      tick();
      check("drain_valid", out_valid, 1'b0);
      check("drain_pc_held", out_pc, 32'h8000_003c);

      // Backpressure: A held while B waits, then B, C, D back to back.
      in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b0;
      tick();
      in_pc = 32'h104;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", in_ready, 1'b0);
         tick();
         check("bp_valid", out_valid, 1'b1);
         check("bp_pc", out_pc, 32'h100);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", in_ready, 1'b1);
      tick();
      check("bp_b_pc", out_pc, 32'h104);
      in_pc = 32'h108;
      tick();
      check("bp_c_pc", out_pc, 32'h108);
      check("bp_c_valid", out_valid, 1'b1);
      in_pc = 32'h10c;
      tick();
      check("bp_d_pc", out_pc, 32'h10c);
      in_valid = 1'b0;
      tick();
      check("bp_drained", out_valid, 1'b0);

      // Flush in the same cycle as a handshake while an entry is held.
      in_valid = 1'b1; in_pc = 32'h200; out_ready = 1'b0;
      tick();
      check("fl_held", out_valid, 1'b1);
      in_pc = 32'h204; out_ready = 1'b1; flush = 1'b1;
      #1;
      check("fl_same_cycle", out_valid, 1'b0);
      check("fl_in_ready", in_ready, 1'b1);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fl_next_cycle", out_valid, 1'b0);
      check("fl_no_load", out_pc, 32'h200);
      tick();
      check("fl_stays_empty", out_valid, 1'b0);

      // Asynchronous reset mid-transfer.
      in_valid = 1'b1; in_pc = 32'h300; out_ready = 1'b0;
      tick();
      check("ar_held", out_valid, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("ar_valid", out_valid, 1'b0);
      check("ar_op", out_op, OP_ILLEGAL);
      check("ar_pc", out_pc, 32'd0);
      in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("ar_after", out_valid, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
